gpio_walk_monitor: RTL and testbench
====================================

Name: gpio_walk_monitor

Overview:
Receive-side checker for the walking-one GPIO pattern the team's sequencer drives. The pattern has one pin high at a time, pin 0 through pin 33, each for prescaler ms, then all pins low. The block watches the 34 breakout-board inputs and measures each pin's dwell time against the programmed prescaler. It raises done on a correct full walk, or error with a cause code, so a second chip or a loopback can self-test the sequencer.

Parameters:
NUM_PINS, 34, number of GPIO inputs monitored; pin indices run 0..NUM_PINS-1
CYCLES_PER_MS, 10000, clk cycles per ms of dwell; expected dwell D = prescaler * CYCLES_PER_MS, 28-bit
TOL, 16, allowed dwell deviation in cycles, ± applied to D
SYNC_STAGES, 2, flip-flop stages on gpio_in before any decision logic

Ports:
clk  in  1  system clock; single clock domain
nrst  in  1  reset, synchronous, active-low
en  in  1  block enable; low forces IDLE
clear  in  1  synchronous clear to IDLE; priority over all but nrst
gpio_in  in  NUM_PINS  asynchronous pin inputs from the breakout board
prescaler  in  14  ms per pin; sampled when leaving IDLE
pin_idx  out  6  index of the current pin, or of the failing pin
dwell_cnt  out  28  measured dwell of the last accepted pin
done  out  1  walk completed correctly; level, held
error  out  1  walk failed; level, held
err_code  out  2  failure cause: 0 none, 1 bad pattern, 2 dwell out of range, 3 prescaler zero

Behaviour:
- Reset (nrst=0 at a clk edge): synchronizer flops, state, pin_idx, dwell_cnt, the internal counter cnt, done, error and err_code all go to 0. State goes to IDLE.
- Synchronizer: gpio_in passes SYNC_STAGES flops to give s. All comparisons use s. The synchronizer keeps running in every state, including under clear and en=0.
- Dwell window: lo = max(D-TOL, 1), hi = D+TOL. Both are computed from the latched prescaler at 28-bit width. hi saturates at 2^28-1.
- IDLE: all outputs 0.
  - en=1 and clear=0: latch prescaler.
  - Latched value 0 -> ERR with err_code=3.
  - Otherwise -> ARMED.
- ARMED: wait for the walk to start.
  - s==0: stay.
  - s==onehot(0): -> DWELL, pin_idx=0, cnt=1.
  - Any other s: -> ERR with err_code=1, pin_idx=0.
- DWELL, while s==onehot(pin_idx): cnt increments.
  - When cnt reaches hi+1 -> ERR with err_code=2. This is a stuck pin; the error fires without waiting for a change.
- DWELL, when s changes:
  - cnt outside [lo, hi] -> ERR with err_code=2.
  - Else, if pin_idx<NUM_PINS-1 and s==onehot(pin_idx+1): pin_idx+1, dwell_cnt=cnt, cnt=1.
  - Else, if pin_idx==NUM_PINS-1 and s==0: dwell_cnt=cnt, -> DONE.
  - Else -> ERR with err_code=1. This covers a skipped pin, two-hot, or 0 in mid-walk. Transitions must be single-cycle at s.
  - The dwell range check has priority over the pattern check in the same cycle.
- DONE: done=1, pin_idx=NUM_PINS-1. Held until clear=1 or en=0.
- ERR: error=1, err_code held, pin_idx holds the failing pin. Held until clear=1 or en=0.
- clear=1 or en=0 in any state -> IDLE next cycle; outputs return to 0 that same cycle. A new walk needs a new arm from IDLE.
- done and error are mutually exclusive; never both 1.
- Latency: s lags gpio_in by SYNC_STAGES cycles. done, error and pin_idx updates appear one cycle after the deciding s value, i.e. SYNC_STAGES+1 cycles after the pin edge.
- All outputs are registered.

Test Plan:
Unless noted, the bench uses CYCLES_PER_MS=10, TOL=2, prescaler=2, giving D=20, lo=18, hi=22.
1. Nominal walk: each pin 0..33 high alone for exactly 20 cycles, then all low -> done=1 exactly 3 cycles after pin 33 falls, with error=0, pin_idx=33, dwell_cnt=20.
2. Short dwell: pin 5 high for 17 cycles, then pin 6 -> error=1, err_code=2, pin_idx=5, done=0.
3. Skipped pin: pin 3 (20 cycles) goes straight to pin 5 -> err_code=1, pin_idx=3. Repeat with pins 3 and 4 overlapping by one cycle -> err_code=1.
4. Stuck pin: pin 10 held high indefinitely -> error rises when cnt=23, err_code=2, pin_idx=10, no further change.
5. Config and edge tolerance:
   - prescaler=0, en rising -> err_code=3 one cycle after arming.
   - Dwells of exactly 18 and exactly 22 are accepted.
6. Abort and recovery:
   - clear pulsed mid-walk at pin 12 -> all outputs 0 next cycle.
   - A fresh nominal walk then completes with done=1.
   - Repeat the abort with nrst=0 for one cycle -> same result.

Source files
------------

// File: rtl/gpio_walk_monitor.sv
// Receive-side checker for a walking-one GPIO pattern. Each pin must be the only
// one high for prescaler ms, pins in order 0..NUM_PINS-1, then all pins low.
// Each pin's dwell is measured against a +/-TOL window. A correct walk raises
// done. Any fault raises error with a cause code.
module gpio_walk_monitor #(
  parameter int unsigned NUM_PINS      = 34,
  parameter int unsigned CYCLES_PER_MS = 10000,
  parameter int unsigned TOL           = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                clear,
  input  logic [NUM_PINS-1:0] gpio_in,
  input  logic [13:0]         prescaler,
  output logic [5:0]          pin_idx,
  output logic [27:0]         dwell_cnt,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code
);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrPattern = 2'd1;
  localparam logic [1:0] ErrDwell   = 2'd2;
  localparam logic [1:0] ErrPresc   = 2'd3;
  localparam logic [5:0] LastPin    = 6'(NUM_PINS - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StDwell, StDone, StErr} state_e;

  state_e        state_q;
  logic [13:0]   presc_q;
  logic [27:0]   cnt_q;
  logic [5:0]    pin_idx_q;
  logic [27:0]   dwell_cnt_q;
  logic          done_q;
  logic          error_q;
  logic [1:0]    err_code_q;

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] s;
  logic [NUM_PINS-1:0] cur_hot;
  logic [NUM_PINS-1:0] nxt_hot;
  logic [27:0]         d_val;
  logic [28:0]         hi_wide;
  logic [27:0]         lo;
  logic [27:0]         hi;

  // Synchronizer chain; cleared only by reset, runs through clear and en=0.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Dwell window from the latched prescaler; hi saturates, lo floors at 1.
  always_comb begin
    d_val   = 28'(presc_q) * 28'(CYCLES_PER_MS);
    hi_wide = {1'b0, d_val} + 29'(TOL);
    hi      = hi_wide[28] ? '1 : hi_wide[27:0];
    lo      = (d_val > 28'(TOL)) ? (d_val - 28'(TOL)) : 28'd1;
    cur_hot = NUM_PINS'(1) << pin_idx_q;
    // Shifts out to zero past the last pin; the last-pin case is guarded separately.
    nxt_hot = cur_hot << 1;
  end

  // Walk FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      cnt_q       <= '0;
      pin_idx_q   <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ErrNone;
    end else if (clear || !en) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pin_idx_q   <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      case (state_q)
        StIdle: begin
          presc_q <= prescaler;
          if (prescaler == 14'd0) begin
            state_q    <= StErr;
            error_q    <= 1'b1;
            err_code_q <= ErrPresc;
          end else begin
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (s == '0) begin
            state_q <= StArmed;
          end else if (s == NUM_PINS'(1)) begin
            state_q   <= StDwell;
            pin_idx_q <= '0;
            cnt_q     <= 28'd1;
          end else begin
            state_q    <= StErr;
            pin_idx_q  <= '0;
            error_q    <= 1'b1;
            err_code_q <= ErrPattern;
          end
        end
        StDwell: begin
          if (s == cur_hot) begin
            // Stuck pin: fire as soon as the count would pass hi.
            if (cnt_q >= hi) begin
              state_q    <= StErr;
              error_q    <= 1'b1;
              err_code_q <= ErrDwell;
            end else begin
              cnt_q <= cnt_q + 28'd1;
            end
          end else if ((cnt_q < lo) || (cnt_q > hi)) begin
            state_q    <= StErr;
            error_q    <= 1'b1;
            err_code_q <= ErrDwell;
          end else if ((pin_idx_q < LastPin) && (s == nxt_hot)) begin
            pin_idx_q   <= pin_idx_q + 6'd1;
            dwell_cnt_q <= cnt_q;
            cnt_q       <= 28'd1;
          end else if ((pin_idx_q == LastPin) && (s == '0)) begin
            dwell_cnt_q <= cnt_q;
            state_q     <= StDone;
            done_q      <= 1'b1;
          end else begin
            state_q    <= StErr;
            error_q    <= 1'b1;
            err_code_q <= ErrPattern;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        StErr: begin
          state_q <= StErr;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pin_idx   = pin_idx_q;
  assign dwell_cnt = dwell_cnt_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_gpio_walk_monitor.sv
// Directed bench for gpio_walk_monitor with D=20, window [18,22].
module tb_gpio_walk_monitor;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        clear;
  logic [33:0] gpio_in;
  logic [13:0] prescaler;
  logic [5:0]  pin_idx;
  logic [27:0] dwell_cnt;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int total;
  int bad;

  gpio_walk_monitor #(
    .NUM_PINS     (34),
    .CYCLES_PER_MS(10),
    .TOL          (2),
    .SYNC_STAGES  (2)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .clear    (clear),
    .gpio_in  (gpio_in),
    .prescaler(prescaler),
    .pin_idx  (pin_idx),
    .dwell_cnt(dwell_cnt),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pin(input int p, input int n);
    logic [33:0] one;
    one = 34'd1;
    gpio_in = one << p;
    repeat (n) tick();
  endtask

  // Return to IDLE with the pins low, then arm with prescaler=2.
  task automatic arm();
    en = 1'b1;
    prescaler = 14'd2;
    gpio_in = '0;
    clear = 1'b1;
    repeat (3) tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    en = 1'b1;
    clear = 1'b0;
    prescaler = 14'd2;
    gpio_in = 34'h3_FFFF_FFFF;
    repeat (3) tick();
    total++;
    if ({done, error, err_code, pin_idx, dwell_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got done=%0b err=%0b code=%0d pin=%0d dwell=%0d want all 0",
               done, error, err_code, pin_idx, dwell_cnt);
    end
    en = 1'b0;
    gpio_in = '0;
    nrst = 1'b1;
    repeat (3) tick();
    total++;
    if ({done, error, err_code} !== 4'd0) begin
      bad++;
      $display("FAIL idle_en0: got done=%0b err=%0b code=%0d want 0", done, error, err_code);
    end
  endtask

  task automatic test_nominal();
    arm();
    for (int p = 0; p < 34; p++) begin
      drive_pin(p, 20);
      if (p == 16) begin
        total++;
        if (pin_idx !== 6'd16 || dwell_cnt !== 28'd20) begin
          bad++;
          $display("FAIL nominal_mid: got pin=%0d dwell=%0d want 16/20", pin_idx, dwell_cnt);
        end
      end
    end
    gpio_in = '0;
    tick();
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL nominal_early_done: got %0b want 0", done);
    end
    tick();
    total++;
    if (done !== 1'b1 || error !== 1'b0 || pin_idx !== 6'd33 || dwell_cnt !== 28'd20) begin
      bad++;
      $display("FAIL nominal_done: got done=%0b err=%0b pin=%0d dwell=%0d want 1/0/33/20",
               done, error, pin_idx, dwell_cnt);
    end
    repeat (8) tick();
    total++;
    if (done !== 1'b1 || error !== 1'b0) begin
      bad++;
      $display("FAIL nominal_hold: got done=%0b err=%0b want 1/0", done, error);
    end
  endtask

  task automatic test_short_dwell();
    arm();
    for (int p = 0; p < 5; p++) drive_pin(p, 20);
    drive_pin(5, 17);
    drive_pin(6, 6);
    total++;
    if (error !== 1'b1 || err_code !== 2'd2 || pin_idx !== 6'd5 || done !== 1'b0) begin
      bad++;
      $display("FAIL short_dwell: got err=%0b code=%0d pin=%0d done=%0b want 1/2/5/0",
               error, err_code, pin_idx, done);
    end
  endtask

  task automatic test_skipped();
    arm();
    for (int p = 0; p < 4; p++) drive_pin(p, 20);
    drive_pin(5, 6);
    total++;
    if (error !== 1'b1 || err_code !== 2'd1 || pin_idx !== 6'd3 || done !== 1'b0) begin
      bad++;
      $display("FAIL skipped_pin: got err=%0b code=%0d pin=%0d done=%0b want 1/1/3/0",
               error, err_code, pin_idx, done);
    end
  endtask

  task automatic test_overlap();
    arm();
    for (int p = 0; p < 4; p++) drive_pin(p, 20);
    gpio_in = 34'h18;
    tick();
    drive_pin(4, 6);
    total++;
    if (error !== 1'b1 || err_code !== 2'd1 || pin_idx !== 6'd3) begin
      bad++;
      $display("FAIL overlap: got err=%0b code=%0d pin=%0d want 1/1/3", error, err_code, pin_idx);
    end
  endtask

  task automatic test_stuck();
    arm();
    for (int p = 0; p < 10; p++) drive_pin(p, 20);
    // Pin 10 never falls: 2 sync cycles plus 23 counted cycles to the error.
    drive_pin(10, 24);
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL stuck_early: got err=%0b want 0", error);
    end
    tick();
    total++;
    if (error !== 1'b1 || err_code !== 2'd2 || pin_idx !== 6'd10) begin
      bad++;
      $display("FAIL stuck_fire: got err=%0b code=%0d pin=%0d want 1/2/10", error, err_code, pin_idx);
    end
    repeat (10) tick();
    total++;
    if (error !== 1'b1 || err_code !== 2'd2 || pin_idx !== 6'd10 || dwell_cnt !== 28'd20 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL stuck_hold: got err=%0b code=%0d pin=%0d dwell=%0d done=%0b want 1/2/10/20/0",
               error, err_code, pin_idx, dwell_cnt, done);
    end
  endtask

  task automatic test_presc_zero();
    gpio_in = '0;
    en = 1'b0;
    clear = 1'b0;
    prescaler = 14'd0;
    repeat (3) tick();
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL presc0_idle: got err=%0b want 0", error);
    end
    en = 1'b1;
    tick();
    total++;
    if (error !== 1'b1 || err_code !== 2'd3 || done !== 1'b0 || pin_idx !== 6'd0) begin
      bad++;
      $display("FAIL presc0_err: got err=%0b code=%0d done=%0b pin=%0d want 1/3/0/0",
               error, err_code, done, pin_idx);
    end
    en = 1'b0;
    tick();
    total++;
    if (error !== 1'b0 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL en_low_clears: got err=%0b code=%0d want 0/0", error, err_code);
    end
    prescaler = 14'd2;
  endtask

  task automatic test_edge_tol();
    arm();
    for (int p = 0; p < 34; p++) drive_pin(p, (p % 2 == 0) ? 18 : 22);
    gpio_in = '0;
    repeat (3) tick();
    total++;
    if (done !== 1'b1 || error !== 1'b0 || dwell_cnt !== 28'd22 || pin_idx !== 6'd33) begin
      bad++;
      $display("FAIL edge_tol: got done=%0b err=%0b code=%0d dwell=%0d pin=%0d want 1/0/22/33",
               done, error, err_code, dwell_cnt, pin_idx);
    end
  endtask

  task automatic test_abort(input bit use_rst);
    arm();
    for (int p = 0; p < 12; p++) drive_pin(p, 20);
    drive_pin(12, 10);
    total++;
    if (pin_idx !== 6'd12 || dwell_cnt !== 28'd20 || error !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre(rst=%0b): got pin=%0d dwell=%0d err=%0b want 12/20/0",
               use_rst, pin_idx, dwell_cnt, error);
    end
    gpio_in = '0;
    if (use_rst) nrst = 1'b0;
    else clear = 1'b1;
    tick();
    nrst = 1'b1;
    clear = 1'b0;
    total++;
    if ({done, error, err_code, pin_idx, dwell_cnt} !== '0) begin
      bad++;
      $display("FAIL abort_outputs(rst=%0b): got done=%0b err=%0b code=%0d pin=%0d dwell=%0d want 0",
               use_rst, done, error, err_code, pin_idx, dwell_cnt);
    end
    repeat (3) tick();
    for (int p = 0; p < 34; p++) drive_pin(p, 20);
    gpio_in = '0;
    repeat (3) tick();
    total++;
    if (done !== 1'b1 || error !== 1'b0 || pin_idx !== 6'd33) begin
      bad++;
      $display("FAIL abort_recover(rst=%0b): got done=%0b err=%0b pin=%0d want 1/0/33",
               use_rst, done, error, pin_idx);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    nrst = 1'b0;
    en = 1'b0;
    clear = 1'b0;
    gpio_in = '0;
    prescaler = 14'd2;
    test_reset();
    test_nominal();
    test_short_dwell();
    test_skipped();
    test_overlap();
    test_stuck();
    test_presc_zero();
    test_edge_tol();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // done and error must never be high together.
  always @(negedge clk) begin
    if (nrst && done && error) begin
      bad++;
      total++;
      $display("FAIL exclusive: got done=1 error=1 want not both");
    end
  end

endmodule
